ram_fifo_ctrl: RTL

- FIFO controller that sits directly upstream of the 8x4 single-port RAM (ram_4x8).
- Turns a push/pop stream interface into the RAM's addr/rw/data_in signals, and returns the RAM's data_out as popped data.
- Used to buffer 4-bit nibbles between AES datapath stages. The RAM stays a plain storage macro; all pointer, occupancy and arbitration logic lives here.

---
 rtl/ram_fifo_ctrl_pkg.sv | 14 +
 rtl/ram_port_arb.sv | 41 ++++
 rtl/ram_fifo_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the nibble FIFO controller in front of ram_4x8.
package ram_fifo_ctrl_pkg;

   localparam int DATA_W_DEF = 4;
   localparam int ADDR_W_DEF = 3;

   localparam logic RAM_RW_WRITE = 1'b0;
   localparam logic RAM_RW_READ  = 1'b1;

   localparam logic [1:0] GNT_NONE = 2'd0;
   localparam logic [1:0] GNT_WR   = 2'd1;
   localparam logic [1:0] GNT_RD   = 2'd2;

endpackage

// File: rtl/ram_port_arb.sv
// Single RAM port arbiter: one grant per cycle, round-robin on conflicts.
module ram_port_arb
   import ram_fifo_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       want_w,
   input  logic       want_r,
   output logic [1:0] gnt
);

   logic prio_q;
   logic prio_d;
   logic conflict;

   assign conflict = want_w & want_r;

   // prio_q=0 favours the read side, and flips only after a conflict
   always_comb begin
      gnt    = GNT_NONE;
      prio_d = prio_q;
      unique case (1'b1)
         conflict: begin
            gnt    = prio_q ? GNT_WR : GNT_RD;
            prio_d = ~prio_q;
         end
         (want_w & ~want_r): gnt = GNT_WR;
         (want_r & ~want_w): gnt = GNT_RD;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving the 8x4 single-port RAM from a push/pop stream.
module ram_fifo_ctrl
   import ram_fifo_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_valid,
   output logic              push_ready,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop_req,
   output logic              pop_ack,
   output logic              pop_valid,
   output logic [DATA_W-1:0] pop_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rw,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);

   logic [ADDR_W-1:0] wr_ptr_q;
   logic [ADDR_W-1:0] wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q;
   logic [ADDR_W-1:0] rd_ptr_d;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_d;
   logic              pop_valid_q;
   logic              pop_valid_d;
   logic              want_w;
   logic              want_r;
   logic [1:0]        gnt;

   assign count = count_q;
   assign full  = (count_q == (ADDR_W+1)'(DEPTH));
   assign empty = (count_q == '0);

   assign want_w = push_valid & ~full;
   assign want_r = pop_req & ~empty;

   ram_port_arb u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .want_w (want_w),
      .want_r (want_r),
      .gnt    (gnt)
   );

   assign push_ready = want_w & (gnt == GNT_WR);
   assign pop_ack    = want_r & (gnt == GNT_RD);

   // Idle cycles issue a harmless read at rd_ptr so the RAM is never written
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pop_valid_d = 1'b0;
      ram_rw      = RAM_RW_READ;
      ram_addr    = rd_ptr_q;
      ram_data_in = '0;
      unique case (gnt)
         GNT_WR: begin
            ram_rw      = RAM_RW_WRITE;
            ram_addr    = wr_ptr_q;
            ram_data_in = push_data;
            wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
            count_d     = count_q + (ADDR_W+1)'(1);
         end
         GNT_RD: begin
            rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
            count_d     = count_q - (ADDR_W+1)'(1);
            pop_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         pop_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         pop_valid_q <= pop_valid_d;
      end
   end

   assign pop_valid = pop_valid_q;
   assign pop_data  = pop_valid_q ? ram_data_out : '0;

endmodule
